// File: rtl/full_adder.sv
// Registered WIDTH-bit adder with grouped carry-lookahead, ripple between groups.
// Optional zero/ovf flag outputs are compiled in with FULL_ADDER_FLAGS_EN.
module full_adder #(
    parameter int WIDTH     = 1,
    parameter int CLA_GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             out_valid
`ifdef FULL_ADDER_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    // A group wider than the operand (e.g. the 1-bit default) collapses to one group.
    localparam int GRP  = (CLA_GROUP < 1) ? 1 :
                          (CLA_GROUP > WIDTH) ? WIDTH : CLA_GROUP;
    localparam int NGRP = (WIDTH + GRP - 1) / GRP;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] sum_n;
    logic             cout_n;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar gi = 0; gi < NGRP; gi++) begin : grp
        localparam int BASE = gi * GRP;
        localparam int LEN  = (WIDTH - BASE < GRP) ? (WIDTH - BASE) : GRP;

        logic           ci;
        logic           co;
        logic [LEN-1:0] gl;
        logic [LEN-1:0] pl;
        logic [LEN:0]   cl;

        if (gi == 0) begin : g_first
            assign ci = cin;
        end else begin : g_next
            assign ci = grp[gi-1].co;
        end

        assign gl = g[BASE +: LEN];
        assign pl = p[BASE +: LEN];

        // Each carry is a flat sum of products of the group's g/p and its carry-in.
        always_comb begin
            logic acc;
            logic term;
            acc  = 1'b0;
            term = 1'b0;
            cl   = '0;
            cl[0] = ci;
            for (int k = 0; k < LEN; k++) begin
                acc = ci;
                for (int m = 0; m <= k; m++) begin
                    acc = acc & pl[m];
                end
                for (int j = 0; j <= k; j++) begin
                    term = gl[j];
                    for (int m = j + 1; m <= k; m++) begin
                        term = term & pl[m];
                    end
                    acc = acc | term;
                end
                cl[k+1] = acc;
            end
        end

        assign sum_n[BASE +: LEN] = pl ^ cl[LEN-1:0];
        assign co                 = cl[LEN];
    end

    assign cout_n = grp[NGRP-1].co;

    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] s_d;
    logic             cout_q;
    logic             cout_d;
    logic             valid_q;

    always_comb begin
        s_d    = s_q;
        cout_d = cout_q;
        if (in_valid) begin
            s_d    = sum_n;
            cout_d = cout_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            cout_q  <= cout_d;
            valid_q <= in_valid;
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;

`ifdef FULL_ADDER_FLAGS_EN
    logic msb_carry_in;
    logic zero_q;
    logic zero_d;
    logic ovf_q;
    logic ovf_d;

    // Carry into the MSB recovered from its sum bit: s = p ^ c.
    assign msb_carry_in = sum_n[WIDTH-1] ^ p[WIDTH-1];

    always_comb begin
        zero_d = zero_q;
        ovf_d  = ovf_q;
        if (in_valid) begin
            zero_d = ~|sum_n;
            ovf_d  = cout_n ^ msb_carry_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign zero = zero_q;
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench: three adder widths against an arithmetic reference model.
// Flag checks are active when FULL_ADDER_FLAGS_EN is defined.
module tb_full_adder;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        z;
        logic        o;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic vin;

    logic [0:0]  a1, b1, s1;
    logic [7:0]  a8, b8, s8;
    logic [12:0] a13, b13, s13;
    logic        c1, c8, c13;
    logic        co1, co8, co13;
    logic        v1, v8, v13;
`ifdef FULL_ADDER_FLAGS_EN
    logic z1, z8, z13, o1, o8, o13;
`endif

    int   nvec = 0;
    int   nerr = 0;
    res_t ex[3];
    logic ev;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1), .CLA_GROUP(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(vin),
        .a(a1), .b(b1), .cin(c1),
        .s(s1), .cout(co1), .out_valid(v1)
`ifdef FULL_ADDER_FLAGS_EN
        , .zero(z1), .ovf(o1)
`endif
    );

    full_adder #(.WIDTH(8), .CLA_GROUP(4)) u8 (
        .clk(clk), .rst(rst), .in_valid(vin),
        .a(a8), .b(b8), .cin(c8),
        .s(s8), .cout(co8), .out_valid(v8)
`ifdef FULL_ADDER_FLAGS_EN
        , .zero(z8), .ovf(o8)
`endif
    );

    full_adder #(.WIDTH(13), .CLA_GROUP(4)) u13 (
        .clk(clk), .rst(rst), .in_valid(vin),
        .a(a13), .b(b13), .cin(c13),
        .s(s13), .cout(co13), .out_valid(v13)
`ifdef FULL_ADDER_FLAGS_EN
        , .zero(z13), .ovf(o13)
`endif
    );

    function automatic res_t add_ref(int w, logic [63:0] a, logic [63:0] b, logic ci);
        res_t        r;
        logic [63:0] sum;
        logic [63:0] mask;
        sum  = a + b + 64'(ci);
        mask = (64'd1 << w) - 64'd1;
        r.s  = sum & mask;
        r.c  = sum[w];
        r.z  = (r.s == 64'd0);
        r.o  = (a[w-1] == b[w-1]) && (r.s[w-1] != a[w-1]);
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 3; i++) ex[i] = '{s: 64'd0, c: 1'b0, z: 1'b0, o: 1'b0};
            ev = 1'b0;
        end else begin
            if (vin) begin
                ex[0] = add_ref(1, 64'(a1), 64'(b1), c1);
                ex[1] = add_ref(8, 64'(a8), 64'(b8), c8);
                ex[2] = add_ref(13, 64'(a13), 64'(b13), c13);
            end
            ev = vin;
        end
        chk("w1_valid", 64'(v1), 64'(ev));
        chk("w1_s", 64'(s1), ex[0].s);
        chk("w1_cout", 64'(co1), 64'(ex[0].c));
        chk("w8_valid", 64'(v8), 64'(ev));
        chk("w8_s", 64'(s8), ex[1].s);
        chk("w8_cout", 64'(co8), 64'(ex[1].c));
        chk("w13_valid", 64'(v13), 64'(ev));
        chk("w13_s", 64'(s13), ex[2].s);
        chk("w13_cout", 64'(co13), 64'(ex[2].c));
`ifdef FULL_ADDER_FLAGS_EN
        chk("w1_zero", 64'(z1), 64'(ex[0].z));
        chk("w1_ovf", 64'(o1), 64'(ex[0].o));
        chk("w8_zero", 64'(z8), 64'(ex[1].z));
        chk("w8_ovf", 64'(o8), 64'(ex[1].o));
        chk("w13_zero", 64'(z13), 64'(ex[2].z));
        chk("w13_ovf", 64'(o13), 64'(ex[2].o));
`endif
    endtask

    task automatic set8(logic [7:0] a, logic [7:0] b, logic ci);
        a8 = a;
        b8 = b;
        c8 = ci;
    endtask

    initial begin
        logic [1:0] t1 [8];
        t1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 3; i++) ex[i] = '{s: 64'd0, c: 1'b0, z: 1'b0, o: 1'b0};
        ev  = 1'b0;
        rst = 1'b1;
        vin = 1'b0;
        a1 = '0; b1 = '0; c1 = 1'b0;
        a13 = '0; b13 = '0; c13 = 1'b0;
        set8(8'd0, 8'd0, 1'b0);
        #1;

        // Reset, then reset colliding with a valid operand set.
        tick();
        vin = 1'b1;
        set8(8'd5, 8'd6, 1'b0);
        tick();
        chk("rst_s", 64'(s8), 64'd0);
        chk("rst_valid", 64'(v8), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_s", 64'(s8), 64'd11);
        chk("post_rst_valid", 64'(v8), 64'd1);

        // Truth table on the 1-bit instance, back-to-back.
        for (int i = 0; i < 8; i++) begin
            a1 = 1'(i >> 2);
            b1 = 1'(i >> 1);
            c1 = 1'(i);
            tick();
            chk("tt_w1", 64'({co1, s1}), 64'(t1[i]));
        end

        // 8-bit wrap-around and overflow corners.
        set8(8'hFF, 8'hFF, 1'b1);
        tick();
        chk("ff_ff_1_s", 64'(s8), 64'hFF);
        chk("ff_ff_1_c", 64'(co8), 64'd1);
        set8(8'hFF, 8'h00, 1'b1);
        tick();
        chk("ff_00_1_s", 64'(s8), 64'h00);
        chk("ff_00_1_c", 64'(co8), 64'd1);
`ifdef FULL_ADDER_FLAGS_EN
        chk("ff_00_1_zero", 64'(z8), 64'd1);
`endif
        set8(8'h7F, 8'h01, 1'b0);
        tick();
        chk("7f_01_s", 64'(s8), 64'h80);
        chk("7f_01_c", 64'(co8), 64'd0);
`ifdef FULL_ADDER_FLAGS_EN
        chk("7f_01_ovf", 64'(o8), 64'd1);
`endif
        set8(8'h80, 8'h80, 1'b0);
        tick();
        chk("80_80_s", 64'(s8), 64'h00);
        chk("80_80_c", 64'(co8), 64'd1);
`ifdef FULL_ADDER_FLAGS_EN
        chk("80_80_ovf", 64'(o8), 64'd1);
        chk("80_80_zero", 64'(z8), 64'd1);
`endif

        // Hold: one valid result, then three idle cycles.
        set8(8'd3, 8'd4, 1'b0);
        tick();
        chk("hold_s0", 64'(s8), 64'd7);
        chk("hold_v0", 64'(v8), 64'd1);
        vin = 1'b0;
        set8(8'd90, 8'd17, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_s", 64'(s8), 64'd7);
            chk("hold_v", 64'(v8), 64'd0);
        end

        // Random back-to-back traffic, sparse idles and occasional resets.
        for (int i = 0; i < 10000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            vin = ($urandom_range(0, 9) != 0);
            a1  = 1'($urandom);
            b1  = 1'($urandom);
            c1  = 1'($urandom);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            c8  = 1'($urandom);
            a13 = 13'($urandom);
            b13 = 13'($urandom);
            c13 = 1'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
